// File: rtl/decm.sv
// decm: RV32I decode stage. Takes an instruction and its PC from fetch,
// reads rs1/rs2 combinationally and registers an execute command bundle
// in a one-entry valid/ready pipeline register with branch flush.
// Optional feature macro: DECM_ILLEGAL_EN adds illegal_o, which flags
// instructions decoded as unsupported NOPs.
module decm (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [4:0]  reg_raddr1_o,
    output logic [4:0]  reg_raddr2_o,
    input  logic [31:0] reg_rdata1_i,
    input  logic [31:0] reg_rdata2_i,
    input  logic        flush_i,
    input  logic        output_ready_i,
    output logic        output_valid_o,
`ifdef DECM_ILLEGAL_EN
    output logic        illegal_o,
`endif
    output logic [31:0] alu_operand1_o,
    output logic [31:0] alu_operand2_o,
    output logic [2:0]  alu_op_o,
    output logic        alu_sub_o,
    output logic        alu_shift_left_o,
    output logic        alu_signed_shift_o,
    output logic [2:0]  branch_cond_o,
    output logic [19:0] branch_offset_o,
    output logic        result_write_o,
    output logic [4:0]  result_addr_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] COND_NONE = 3'b000;
    localparam logic [2:0] COND_JAL  = 3'b001;
    localparam logic [2:0] COND_BEQ  = 3'b010;
    localparam logic [2:0] COND_BNE  = 3'b011;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  alu_op;
        logic        sub;
        logic        shl;
        logic        sra;
        logic [2:0]  cond;
        logic [19:0] offset;
        logic        wr;
        logic [4:0]  rd;
`ifdef DECM_ILLEGAL_EN
        logic        illegal;
`endif
    } cmd_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] u_imm;
    logic [31:0] i_imm;
    logic [31:0] shamt;
    logic        rd_nz;
    logic        nop;
    cmd_t        dec;

    logic        valid_q, valid_d;
    cmd_t        cmd_q, cmd_d;
    logic        in_xfer, out_xfer;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign u_imm  = {instr_i[31:12], 12'b0};
    assign i_imm  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign shamt  = {27'b0, instr_i[24:20]};
    assign rd_nz  = (instr_i[11:7] != 5'd0);

    assign reg_raddr1_o = instr_i[19:15];
    assign reg_raddr2_o = instr_i[24:20];

    assign input_ready_o = !valid_q || output_ready_i;
    assign in_xfer       = input_valid_i && input_ready_o;
    assign out_xfer      = valid_q && output_ready_i;

    // Instruction decode into a command bundle; unsupported encodings collapse to a NOP
    always_comb begin
        dec    = '0;
        nop    = 1'b0;
        dec.rd = instr_i[11:7];
        case (opcode)
            OPC_LUI: begin
                dec.op2 = u_imm;
                dec.wr  = rd_nz;
            end
            OPC_AUIPC: begin
                dec.op1 = pc_i;
                dec.op2 = u_imm;
                dec.wr  = rd_nz;
            end
            OPC_JAL: begin
                dec.op1    = pc_i;
                dec.op2    = 32'd4;
                dec.cond   = COND_JAL;
                dec.offset = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]};
                dec.wr     = rd_nz;
            end
            OPC_BRANCH: begin
                dec.op1    = reg_rdata1_i;
                dec.op2    = reg_rdata2_i;
                dec.sub    = 1'b1;
                dec.offset = {{8{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8]};
                case (funct3)
                    3'b000:         dec.cond = COND_BEQ;
                    3'b001:         dec.cond = COND_BNE;
                    3'b010, 3'b011: nop = 1'b1;
                    // 100..111 map one-to-one onto BLT, BGE, BLTU, BGEU
                    default:        dec.cond = funct3;
                endcase
            end
            OPC_OPIMM: begin
                dec.op1    = reg_rdata1_i;
                dec.op2    = i_imm;
                dec.alu_op = funct3;
                dec.wr     = rd_nz;
                if (funct3 == 3'b001) begin
                    dec.shl = 1'b1;
                    dec.op2 = shamt;
                end
                if (funct3 == 3'b101) begin
                    dec.sra = instr_i[30];
                    dec.op2 = shamt;
                end
            end
            OPC_OP: begin
                dec.op1    = reg_rdata1_i;
                dec.op2    = reg_rdata2_i;
                dec.alu_op = funct3;
                dec.wr     = rd_nz;
                dec.sub    = (funct3 == 3'b000) && instr_i[30];
                dec.shl    = (funct3 == 3'b001);
                dec.sra    = (funct3 == 3'b101) && instr_i[30];
            end
            default: nop = 1'b1;
        endcase
        if (nop) begin
            dec    = '0;
            dec.rd = instr_i[11:7];
`ifdef DECM_ILLEGAL_EN
            dec.illegal = 1'b1;
`endif
        end
    end

    // Pipeline register next state: flush beats a new transfer, which beats drain
    always_comb begin
        valid_d = valid_q;
        cmd_d   = cmd_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_xfer) begin
            valid_d = 1'b1;
            cmd_d   = dec;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
        end
    end

    assign output_valid_o     = valid_q;
    assign alu_operand1_o     = cmd_q.op1;
    assign alu_operand2_o     = cmd_q.op2;
    assign alu_op_o           = cmd_q.alu_op;
    assign alu_sub_o          = cmd_q.sub;
    assign alu_shift_left_o   = cmd_q.shl;
    assign alu_signed_shift_o = cmd_q.sra;
    assign branch_cond_o      = cmd_q.cond;
    assign branch_offset_o    = cmd_q.offset;
    assign result_write_o     = cmd_q.wr;
    assign result_addr_o      = cmd_q.rd;
`ifdef DECM_ILLEGAL_EN
    assign illegal_o          = cmd_q.illegal;
`endif

endmodule

// File: tb/tb_decm.sv
// tb_decm: directed self-checking bench for the decm decode stage.
module tb_decm;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        input_valid_i;
    logic        input_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [4:0]  reg_raddr1_o;
    logic [4:0]  reg_raddr2_o;
    logic [31:0] reg_rdata1_i;
    logic [31:0] reg_rdata2_i;
    logic        flush_i;
    logic        output_ready_i;
    logic        output_valid_o;
`ifdef DECM_ILLEGAL_EN
    logic        illegal_o;
`endif
    logic [31:0] alu_operand1_o;
    logic [31:0] alu_operand2_o;
    logic [2:0]  alu_op_o;
    logic        alu_sub_o;
    logic        alu_shift_left_o;
    logic        alu_signed_shift_o;
    logic [2:0]  branch_cond_o;
    logic [19:0] branch_offset_o;
    logic        result_write_o;
    logic [4:0]  result_addr_o;

    int n_assert = 0;
    int n_fail   = 0;

    decm dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .input_valid_i      (input_valid_i),
        .input_ready_o      (input_ready_o),
        .instr_i            (instr_i),
        .pc_i               (pc_i),
        .reg_raddr1_o       (reg_raddr1_o),
        .reg_raddr2_o       (reg_raddr2_o),
        .reg_rdata1_i       (reg_rdata1_i),
        .reg_rdata2_i       (reg_rdata2_i),
        .flush_i            (flush_i),
        .output_ready_i     (output_ready_i),
        .output_valid_o     (output_valid_o),
`ifdef DECM_ILLEGAL_EN
        .illegal_o          (illegal_o),
`endif
        .alu_operand1_o     (alu_operand1_o),
        .alu_operand2_o     (alu_operand2_o),
        .alu_op_o           (alu_op_o),
        .alu_sub_o          (alu_sub_o),
        .alu_shift_left_o   (alu_shift_left_o),
        .alu_signed_shift_o (alu_signed_shift_o),
        .branch_cond_o      (branch_cond_o),
        .branch_offset_o    (branch_offset_o),
        .result_write_o     (result_write_o),
        .result_addr_o      (result_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock, sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
        instr_i      = ins;
        pc_i         = pc;
        reg_rdata1_i = r1;
        reg_rdata2_i = r2;
    endtask

    initial begin
        rst_i          = 1'b1;
        input_valid_i  = 1'b0;
        flush_i        = 1'b0;
        output_ready_i = 1'b0;
        put(32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();

        // reset state
        chk("rst_valid", 32'(output_valid_o), 32'h0);
        chk("rst_op1",   alu_operand1_o, 32'h0);
        chk("rst_op2",   alu_operand2_o, 32'h0);
        chk("rst_wr",    32'(result_write_o), 32'h0);
        chk("rst_addr",  32'(result_addr_o), 32'h0);
        chk("rst_cond",  32'(branch_cond_o), 32'h0);
        chk("rst_ready", 32'(input_ready_o), 32'h1);
        rst_i = 1'b0;

        // ADDI x5,x1,-3
        output_ready_i = 1'b1;
        input_valid_i  = 1'b1;
        put(32'hFFD08293, 32'h0, 32'd10, 32'h0);
        #1;
        chk("raddr1", 32'(reg_raddr1_o), 32'd1);
        chk("raddr2", 32'(reg_raddr2_o), 32'd29);
        tick();
        chk("addi_valid", 32'(output_valid_o), 32'h1);
        chk("addi_op1",   alu_operand1_o, 32'd10);
        chk("addi_op2",   alu_operand2_o, 32'hFFFFFFFD);
        chk("addi_aluop", 32'(alu_op_o), 32'h0);
        chk("addi_wr",    32'(result_write_o), 32'h1);
        chk("addi_addr",  32'(result_addr_o), 32'd5);
        chk("addi_cond",  32'(branch_cond_o), 32'h0);
        chk("addi_off",   32'(branch_offset_o), 32'h0);
`ifdef DECM_ILLEGAL_EN
        chk("addi_illegal", 32'(illegal_o), 32'h0);
`endif

        // SUB x3,x1,x2 back-to-back
        put(32'h402081B3, 32'h0, 32'd7, 32'd9);
        tick();
        chk("sub_valid", 32'(output_valid_o), 32'h1);
        chk("sub_op1",   alu_operand1_o, 32'd7);
        chk("sub_op2",   alu_operand2_o, 32'd9);
        chk("sub_sub",   32'(alu_sub_o), 32'h1);
        chk("sub_aluop", 32'(alu_op_o), 32'h0);
        chk("sub_addr",  32'(result_addr_o), 32'd3);
        chk("sub_wr",    32'(result_write_o), 32'h1);

        // BEQ x1,x2,-8
        put(32'hFE208CE3, 32'h0, 32'd1, 32'd2);
        tick();
        chk("beq_cond", 32'(branch_cond_o), 32'h2);
        chk("beq_off",  32'(branch_offset_o), 32'hFFFFC);
        chk("beq_wr",   32'(result_write_o), 32'h0);
        chk("beq_sub",  32'(alu_sub_o), 32'h1);
        chk("beq_op2",  alu_operand2_o, 32'd2);

        // LUI x7,0x12345
        put(32'h123453B7, 32'h0, 32'hDEAD, 32'h0);
        tick();
        chk("lui_op1",  alu_operand1_o, 32'h0);
        chk("lui_op2",  alu_operand2_o, 32'h12345000);
        chk("lui_addr", 32'(result_addr_o), 32'd7);
        chk("lui_wr",   32'(result_write_o), 32'h1);

        // AUIPC x1,0x1 at pc 0x100
        put(32'h00001097, 32'h100, 32'h0, 32'h0);
        tick();
        chk("auipc_op1", alu_operand1_o, 32'h100);
        chk("auipc_op2", alu_operand2_o, 32'h1000);
        chk("auipc_sub", 32'(alu_sub_o), 32'h0);

        // JAL x1,+8 at pc 0x200
        put(32'h008000EF, 32'h200, 32'h0, 32'h0);
        tick();
        chk("jal_op1",  alu_operand1_o, 32'h200);
        chk("jal_op2",  alu_operand2_o, 32'd4);
        chk("jal_cond", 32'(branch_cond_o), 32'h1);
        chk("jal_off",  32'(branch_offset_o), 32'h4);
        chk("jal_wr",   32'(result_write_o), 32'h1);

        // SRAI x2,x3,4
        put(32'h4041D113, 32'h0, 32'h80, 32'h0);
        tick();
        chk("srai_op2",   alu_operand2_o, 32'd4);
        chk("srai_aluop", 32'(alu_op_o), 32'h5);
        chk("srai_sra",   32'(alu_signed_shift_o), 32'h1);
        chk("srai_shl",   32'(alu_shift_left_o), 32'h0);

        // SLLI x2,x3,31
        put(32'h01F19113, 32'h0, 32'h80, 32'h0);
        tick();
        chk("slli_op2",   alu_operand2_o, 32'd31);
        chk("slli_aluop", 32'(alu_op_o), 32'h1);
        chk("slli_shl",   32'(alu_shift_left_o), 32'h1);
        chk("slli_sra",   32'(alu_signed_shift_o), 32'h0);

        // ADDI x0,x0,1 : rd=0 never writes
        put(32'h00100013, 32'h0, 32'h0, 32'h0);
        tick();
        chk("x0_wr",  32'(result_write_o), 32'h0);
        chk("x0_op2", alu_operand2_o, 32'd1);

        // LW x3,0(x1) : unsupported -> NOP
        put(32'h0000A183, 32'h0, 32'h1234, 32'h5678);
        tick();
        chk("lw_valid", 32'(output_valid_o), 32'h1);
        chk("lw_op1",   alu_operand1_o, 32'h0);
        chk("lw_op2",   alu_operand2_o, 32'h0);
        chk("lw_wr",    32'(result_write_o), 32'h0);
        chk("lw_cond",  32'(branch_cond_o), 32'h0);
`ifdef DECM_ILLEGAL_EN
        chk("lw_illegal", 32'(illegal_o), 32'h1);
`endif

        // drain with no new input
        input_valid_i = 1'b0;
        tick();
        chk("drain_valid", 32'(output_valid_o), 32'h0);

        // backpressure: A accepted, then stalled while B waits
        input_valid_i  = 1'b1;
        output_ready_i = 1'b0;
        put(32'hFFD08293, 32'h0, 32'd1, 32'h0);
        tick();
        chk("bp_a_valid", 32'(output_valid_o), 32'h1);
        chk("bp_a_op1",   alu_operand1_o, 32'd1);
        chk("bp_ready0",  32'(input_ready_o), 32'h0);
        put(32'hFFD08293, 32'h0, 32'd2, 32'h0);
        tick();
        chk("bp_hold1_op1", alu_operand1_o, 32'd1);
        tick();
        chk("bp_hold2_op1",  alu_operand1_o, 32'd1);
        chk("bp_hold2_op2",  alu_operand2_o, 32'hFFFFFFFD);
        chk("bp_hold2_addr", 32'(result_addr_o), 32'd5);
        chk("bp_hold2_vld",  32'(output_valid_o), 32'h1);
        output_ready_i = 1'b1;
        #1;
        chk("bp_ready1", 32'(input_ready_o), 32'h1);
        tick();
        chk("bp_b_op1",  alu_operand1_o, 32'd2);
        chk("bp_b_vld",  32'(output_valid_o), 32'h1);
        put(32'hFFD08293, 32'h0, 32'd3, 32'h0);
        tick();
        chk("bp_c_op1",  alu_operand1_o, 32'd3);
        chk("bp_c_vld",  32'(output_valid_o), 32'h1);
        input_valid_i = 1'b0;
        tick();
        chk("bp_end_vld", 32'(output_valid_o), 32'h0);

        // flush kills the valid bundle and the instruction transferring with it
        input_valid_i = 1'b1;
        put(32'hFFD08293, 32'h0, 32'h55, 32'h0);
        tick();
        chk("fl_pre_vld", 32'(output_valid_o), 32'h1);
        put(32'hFFD08293, 32'h0, 32'h66, 32'h0);
        flush_i = 1'b1;
        tick();
        chk("fl_vld", 32'(output_valid_o), 32'h0);
        flush_i       = 1'b0;
        input_valid_i = 1'b0;
        tick();
        chk("fl_after_vld", 32'(output_valid_o), 32'h0);
        chk("fl_no_ghost",  32'(alu_operand1_o == 32'h66), 32'h0);

        // reset mid-stream while a bundle is held
        input_valid_i  = 1'b1;
        output_ready_i = 1'b1;
        put(32'h402081B3, 32'h0, 32'd7, 32'd9);
        tick();
        chk("mr_pre_vld", 32'(output_valid_o), 32'h1);
        output_ready_i = 1'b0;
        rst_i          = 1'b1;
        tick();
        chk("mr_vld",   32'(output_valid_o), 32'h0);
        chk("mr_op1",   alu_operand1_o, 32'h0);
        chk("mr_op2",   alu_operand2_o, 32'h0);
        chk("mr_sub",   32'(alu_sub_o), 32'h0);
        chk("mr_addr",  32'(result_addr_o), 32'h0);
        chk("mr_wr",    32'(result_write_o), 32'h0);
        chk("mr_ready", 32'(input_ready_o), 32'h1);
        rst_i         = 1'b0;
        input_valid_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/decm.md
Name: decm

Overview:
Decode stage of the ECAP5-DPROC RV32I pipeline. Sits between fetch and the execute stage.
- Accepts an instruction and its PC over a valid/ready handshake.
- Reads two register-file ports combinationally.
- Emits a registered execute-stage command bundle: ALU operands and controls, branch condition and offset, writeback target.
- One-entry pipeline register with backpressure and branch flush.

Parameters:
none

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
input_valid_i  input  1  fetch has a valid instruction
input_ready_o  output  1  decm can accept an instruction this cycle
instr_i  input  32  instruction word
pc_i  input  32  PC of instr_i
reg_raddr1_o  output  5  rs1 address, combinational from instr_i[19:15]
reg_raddr2_o  output  5  rs2 address, combinational from instr_i[24:20]
reg_rdata1_i  input  32  rs1 data, same cycle
reg_rdata2_i  input  32  rs2 data, same cycle
flush_i  input  1  taken branch from execute; kill in-flight decode
output_ready_i  input  1  execute accepts the command
output_valid_o  output  1  command valid
alu_operand1_o  output  32  ALU operand 1
alu_operand2_o  output  32  ALU operand 2
alu_op_o  output  3  funct3-style op: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SR, 110 OR, 111 AND
alu_sub_o  output  1  subtract
alu_shift_left_o  output  1  shift direction is left
alu_signed_shift_o  output  1  arithmetic right shift
branch_cond_o  output  3  000 NONE, 001 JAL, 010 BEQ, 011 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
branch_offset_o  output  20  target offset / 2, sign-extended
result_write_o  output  1  write rd
result_addr_o  output  5  rd

Behaviour:
- Clock and reset are fixed: one clock, clk_i; rst_i is synchronous and active-high.
- Reset: output_valid_o=0, and every registered output is 0.
- input_ready_o = !output_valid_o || output_ready_i. It is combinational and is not gated by rst_i.
- Input transfer occurs on input_valid_i && input_ready_o. The decoded bundle is registered on that edge, and output_valid_o=1 on the next cycle. Latency is 1 cycle.
- Output transfer occurs on output_valid_o && output_ready_i. If there is no new input transfer in that cycle, output_valid_o drops to 0 next cycle.
- Back-to-back transfers sustain 1 instruction per cycle.
- Hold: when output_valid_o=1 and output_ready_i=0, all outputs stay stable.
- flush_i=1: output_valid_o=0 next cycle. Any input transferred in the same cycle is discarded. Flush has priority over input transfer.
- rst_i has priority over flush_i and over any transfer.
- Decode, by opcode:
  - LUI: op1=0; op2=U-imm; ADD.
  - AUIPC: op1=pc_i; op2=U-imm; ADD.
  - JAL: op1=pc_i; op2=4; ADD; cond=JAL; offset={i[31],i[19:12],i[20],i[30:21]}.
  - BRANCH: op1=rs1; op2=rs2; ADD with sub=1; cond from funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU); offset={{8{i[31]}},i[31],i[7],i[30:25],i[11:8]}; result_write=0.
    - funct3 010/011 decode as NOP.
  - OP-IMM: op1=rs1; op2=sign-extended I-imm; alu_op=funct3.
    - funct3 001: shift_left=1.
    - funct3 101: signed_shift=i[30].
    - Shifts use op2 = zero-extended shamt i[24:20].
  - OP: op1=rs1; op2=rs2; alu_op=funct3; sub=i[30] when funct3=000; shift flags as for OP-IMM.
- result_write_o=1 only for LUI, AUIPC, JAL, OP-IMM and OP, and only when rd!=0.
- Unsupported (LOAD, STORE, JALR, MISC-MEM, SYSTEM, unknown opcode) decodes as a NOP: op1=op2=0, ADD, cond=NONE, result_write=0, valid still asserted.
- Flags not named above are 0; branch_offset_o=0 when cond=NONE.

Optional Feature:
Macro: DECM_ILLEGAL_EN.
- Defined: adds port illegal_o (output, 1). It is registered with the bundle and is 1 for every instruction decoded as an unsupported NOP. Reset value is 0.
- Undefined: the port is absent and unsupported instructions are silently NOPs.

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293), rdata1=10 -> next cycle: valid=1, op1=10, op2=0xFFFFFFFD, alu_op=000, result_write=1, addr=5, cond=NONE.
- SUB x3,x1,x2 (0x402081B3), rdata1=7, rdata2=9 -> op1=7, op2=9, alu_sub=1, alu_op=000, addr=3.
- BEQ x1,x2,-8 (0xFE208CE3) -> cond=010, offset=0xFFFFC, result_write=0.
- Backpressure: 3 instructions issued with output_ready_i=0 after the first -> input_ready_o=0 and the first bundle held stable. Release -> the remaining two delivered in order at 1 per cycle.
- flush_i pulsed while valid=1 and a new input transfers -> next cycle valid=0, and the discarded instruction never appears.
- rst_i asserted mid-stream with valid=1 -> next cycle all outputs 0 and input_ready_o=1. LW (0x0000A183) -> NOP; illegal_o=1 when DECM_ILLEGAL_EN is defined.
